// File: rtl/master_bridge_axi_req_splitter.sv
// Splits one PCIe memory request into legal AXI4 INCR bursts. Bursts are cut at
// the address boundary and the max-burst limit, and issue is throttled by the outstanding-burst count.
module master_bridge_axi_req_splitter #(
  parameter int ADDR_WIDTH        = 64,
  parameter int ID_WIDTH          = 10,
  parameter int AxLEN_FIELD_WIDTH = 8,
  parameter int BEAT_BYTES        = 128,
  parameter int MAX_BURST_BEATS   = 256,
  parameter int BOUNDARY_BYTES    = 4096,
  parameter int MAX_OUTSTANDING   = 16,
  parameter int CNT_WIDTH         = 5
) (
  input  logic                         i_pcie_clk,
  input  logic                         i_pcie_n_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_is_write,
  input  logic [ADDR_WIDTH-1:0]        i_req_address,
  input  logic [9:0]                   i_req_length,
  input  logic [ID_WIDTH-1:0]          i_req_id,
  output logic                         o_ax_valid,
  input  logic                         i_ax_ready,
  output logic                         o_ax_is_write,
  output logic [ADDR_WIDTH-1:0]        o_ax_addr,
  output logic [AxLEN_FIELD_WIDTH-1:0] o_ax_len,
  output logic [ID_WIDTH-1:0]          o_ax_id,
  output logic [10:0]                  o_ax_dw_count,
  output logic                         o_ax_first,
  output logic                         o_ax_last,
  input  logic                         i_ax_done,
  output logic [CNT_WIDTH-1:0]         o_outstanding,
  output logic                         o_busy
);

  localparam int BEAT_LOG2 = $clog2(BEAT_BYTES);
  localparam int BND_LOG2  = $clog2(BOUNDARY_BYTES);
  localparam logic [31:0] MAX_BURST_BYTES = 32'(MAX_BURST_BEATS * BEAT_BYTES);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic [12:0]            rem_bytes;
  logic [ID_WIDTH-1:0]    cur_id;
  logic                   cur_write;
  logic                   cur_first;
  logic [CNT_WIDTH-1:0]   outstanding;
  logic                   req_ready_q;
  logic                   busy_q;

  logic [31:0] off_beat, to_bnd, max_b, chunk, len_full;
  logic        ax_last, can_issue, ax_hs, done_eff;

  // 32-bit intermediates: chunk never exceeds 4096 and span stays far below 2^32
  always_comb begin
    off_beat = 32'(cur_addr[BEAT_LOG2-1:0]);
    to_bnd   = 32'(BOUNDARY_BYTES) - 32'(cur_addr[BND_LOG2-1:0]);
    max_b    = MAX_BURST_BYTES - off_beat;
    chunk    = 32'(rem_bytes);
    if (to_bnd < chunk) chunk = to_bnd;
    if (max_b < chunk)  chunk = max_b;
    len_full = ((off_beat + chunk + 32'(BEAT_BYTES) - 32'd1) >> BEAT_LOG2) - 32'd1;
  end

  assign ax_last   = (chunk == 32'(rem_bytes));
  assign can_issue = (state == ISSUE) && (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign ax_hs     = can_issue && i_ax_ready;
  assign done_eff  = i_ax_done && (outstanding != '0);

  assign o_req_ready   = req_ready_q;
  assign o_busy        = busy_q;
  assign o_ax_valid    = can_issue;
  assign o_ax_is_write = cur_write;
  assign o_ax_addr     = cur_addr;
  assign o_ax_len      = AxLEN_FIELD_WIDTH'(len_full);
  assign o_ax_id       = cur_id;
  assign o_ax_dw_count = 11'(chunk >> 2);
  assign o_ax_first    = cur_first;
  assign o_ax_last     = ax_last;
  assign o_outstanding = outstanding;

  always_ff @(posedge i_pcie_clk or negedge i_pcie_n_rst) begin
    if (!i_pcie_n_rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      rem_bytes   <= '0;
      cur_id      <= '0;
      cur_write   <= 1'b0;
      cur_first   <= 1'b1;
      outstanding <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid && req_ready_q) begin
            cur_addr    <= i_req_address & ~ADDR_WIDTH'(3);
            rem_bytes   <= (i_req_length == 10'd0) ? 13'd4096 : {1'b0, i_req_length, 2'b00};
            cur_id      <= i_req_id;
            cur_write   <= i_req_is_write;
            cur_first   <= 1'b1;
            state       <= ISSUE;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          if (ax_hs) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(chunk);
            rem_bytes <= rem_bytes - 13'(chunk);
            cur_first <= 1'b0;
            if (ax_last) begin
              state       <= IDLE;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (ax_hs && !done_eff)
        outstanding <= outstanding + 1'b1;
      else if (!ax_hs && done_eff)
        outstanding <= outstanding - 1'b1;
    end
  end

endmodule
